// File: rtl/mul_seq_ctrl_if.sv
// Multiply controller bus: opcode-decoder side (start/operands/result)
// and the shared ripple-carry adder operand/result lines.
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 abort;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     add_a;
    logic [WIDTH-1:0]     add_b;
    logic                 add_cin;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;

    modport slave (
        input  start, abort, op_a, op_b, add_sum, add_cout,
        output busy, done, product, add_a, add_b, add_cin
    );

    modport master (
        output start, abort, op_a, op_b, add_sum, add_cout,
        input  busy, done, product, add_a, add_b, add_cin
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier controller using the ALU adder.
// Ports: clk, rst_n (async, active-low), bus (mul_seq_ctrl_if.slave).
module mul_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     acc_d;
    logic [WIDTH-1:0]     q_d;
    logic                 calc;

    assign calc = (state_q == CALC);

    // Adder sees the partial product and, when the multiplier LSB is set,
    // the multiplicand.
    assign bus.add_a   = calc ? acc_q : '0;
    assign bus.add_b   = (calc && q_q[0]) ? m_q : '0;
    assign bus.add_cin = 1'b0;

    // Carry-out becomes the new ACC MSB, so the product never overflows.
    assign acc_d = {bus.add_cout, bus.add_sum[WIDTH-1:1]};
    assign q_d   = {bus.add_sum[0], q_q[WIDTH-1:1]};

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        m_q     <= bus.op_a;
                        q_q     <= bus.op_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            prod_q  <= {acc_d, q_d};
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: vector table, random vs a*b model,
// and directed ignored-start / back-to-back / abort / async-reset sequences.
module tb_mul_seq_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mul_seq_ctrl_if #(.WIDTH(W)) bus ();

    mul_seq_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stand-in for the ALU's combinational ripple-carry adder.
    assign {bus.add_cout, bus.add_sum} =
        {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           ab;
        logic [2*W-1:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Runs one multiply from a start pulse and returns sampled in the DONE
    // cycle. ACC before step k is the high half of a*(b mod 2^k) shifted by k.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ab, input logic [2*W-1:0] exp,
                           input string nm);
        int nb;
        int bad;
        int eb;
        int ea;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.abort = ab;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);
        nb  = 0;
        bad = 0;
        while (bus.busy && nb < 20) begin
            eb = (nb < W && ((b >> nb) & 1) == 1) ? int'(a) : 0;
            ea = (nb < W) ?
                 ((int'(a) * (int'(b) & ((1 << nb) - 1))) >> nb) & 255 : 0;
            if (bus.add_b !== W'(eb) || bus.add_a !== W'(ea)
                || bus.add_cin !== 1'b0 || bus.done !== 1'b0)
                bad++;
            nb++;
            @(posedge clk);
            #1;
        end
        chk({nm, " busy_cycles"}, nb, W);
        chk({nm, " adder_drive"}, bad, 0);
        chk({nm, " done"}, {31'd0, bus.done}, 1);
        chk({nm, " product"}, {16'd0, bus.product}, {16'd0, exp});
    endtask

    task automatic idle_cycle(input string nm);
        @(posedge clk);
        #1;
        chk({nm, " done_1cyc"}, {31'd0, bus.done}, 0);
        chk({nm, " idle_busy"}, {31'd0, bus.busy}, 0);
        chk({nm, " idle_add_b"}, {24'd0, bus.add_b}, 0);
    endtask

    initial begin
        vec_t vt[6];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2*W-1:0] prev;
        int nd;

        errors = 0;
        checks = 0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        rst_n = 1'b0;

        vt[0] = '{a: 8'd10,  b: 8'd15,  ab: 1'b0, exp: 16'h0096};
        vt[1] = '{a: 8'd255, b: 8'd255, ab: 1'b0, exp: 16'hFE01};
        vt[2] = '{a: 8'd120, b: 8'd111, ab: 1'b0, exp: 16'h3408};
        vt[3] = '{a: 8'd0,   b: 8'd200, ab: 1'b0, exp: 16'h0000};
        vt[4] = '{a: 8'd1,   b: 8'd200, ab: 1'b0, exp: 16'h00C8};
        vt[5] = '{a: 8'd13,  b: 8'd11,  ab: 1'b1, exp: 16'h008F};

        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", {31'd0, bus.busy}, 0);
        chk("rst done", {31'd0, bus.done}, 0);
        chk("rst product", {16'd0, bus.product}, 0);
        chk("rst add_a", {24'd0, bus.add_a}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_mul(vt[i].a, vt[i].b, vt[i].ab, vt[i].exp,
                    $sformatf("vec%0d", i));
            idle_cycle($sformatf("vec%0d", i));
        end

        // Random operands, sometimes issued back-to-back from DONE.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_mul(ra, rb, 1'b0, 16'(int'(ra) * int'(rb)),
                    $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1)
                idle_cycle($sformatf("rnd%0d", i));
        end
        idle_cycle("rnd_end");

        // Start during CALC is ignored; one done pulse with the first result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 8'd10;
        bus.op_b  = 8'd15;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 8'd3;
        bus.op_b  = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                nd++;
                chk("ign_start product", {16'd0, bus.product}, 16'h0096);
            end
        end
        chk("ign_start done_pulses", nd, 1);

        // Back-to-back: second start lands in the DONE cycle.
        run_mul(8'd9, 8'd9, 1'b0, 16'd81, "b2b_first");
        run_mul(8'd2, 8'd7, 1'b0, 16'd14, "b2b_second");
        idle_cycle("b2b");

        // Abort at step 5: no done, product held.
        prev = 16'd14;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 8'd200;
        bus.op_b  = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("abort busy", {31'd0, bus.busy}, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done)
                nd++;
        end
        chk("abort no_done", nd, 0);
        chk("abort product_held", {16'd0, bus.product}, {16'd0, prev});
        run_mul(8'd200, 8'd3, 1'b0, 16'h0258, "after_abort");
        idle_cycle("after_abort");

        // Asynchronous reset between edges in the middle of CALC.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 8'd77;
        bus.op_b  = 8'd99;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst busy", {31'd0, bus.busy}, 0);
        chk("arst done", {31'd0, bus.done}, 0);
        chk("arst product", {16'd0, bus.product}, 0);
        #2;
        rst_n = 1'b1;
        run_mul(8'd10, 8'd15, 1'b0, 16'h0096, "after_rst");
        idle_cycle("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
